// File: rtl/cpu_types_pkg.sv
// Shared types for the core's memory side: word, RAM status encoding and arbiter state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IGRANT = 2'b01,
    DGRANT = 2'b10
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  function automatic logic is_grant(input arb_state_t s);
    return (s == IGRANT) || (s == DGRANT);
  endfunction

endpackage

// File: rtl/arb_stall_counter.sv
// Saturating grant-cycle counter with a sticky flag raised when the count reaches MAX_WAIT.
module arb_stall_counter #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 7
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic en,
  output logic flag
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] count_d;

  // Clear and count may coincide: the first grant cycle is counted as it is entered,
  // so the count equals the number of grant cycles including the current one.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    base    = clr ? '0 : count_q;
    count_d = base;
    if (en && (base != MAX_CNT))
      count_d = base + CNT_W'(1);
  end

  // NOTE: async active-low reset in the sensitivity list; state updates use <= only.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
      flag    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (count_d == MAX_CNT)
        flag <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache fills and dcache accesses onto a single-ported RAM.
// Optional build macro MEM_ARB_RR_EN: round-robin between simultaneous requesters.
module mem_arbiter #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 7
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        timeout
);

  import cpu_types_pkg::*;

  arb_state_t state_q;
  arb_state_t next_state;
  grant_t     last_grant_q;
  ramstate_t  ram_st;
  logic       d_req;
  logic       pick_d;

  assign ram_st = ramstate_t'(ramstate);
  assign d_req  = dREN | dWEN;

`ifdef MEM_ARB_RR_EN
  assign pick_d = (last_grant_q == GRANT_I);
`else
  logic last_grant_unused;
  assign pick_d            = 1'b1;
  assign last_grant_unused = last_grant_q;
`endif

  // A grant ends on completion or when its requester withdraws; either way via IDLE.
  always_comb begin
    next_state = state_q;
    unique case (state_q)
      IDLE: begin
        if (d_req && iREN)
          next_state = pick_d ? DGRANT : IGRANT;
        else if (d_req)
          next_state = DGRANT;
        else if (iREN)
          next_state = IGRANT;
      end
      IGRANT: if (!iREN || (ram_st == ACCESS)) next_state = IDLE;
      DGRANT: if (!d_req || (ram_st == ACCESS)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
    end else begin
      state_q <= next_state;
      if (state_q == IDLE && next_state == IGRANT)
        last_grant_q <= GRANT_I;
      else if (state_q == IDLE && next_state == DGRANT)
        last_grant_q <= GRANT_D;
    end
  end

  // RAM side follows the granted requester live; ERROR/BUSY/FREE simply keep the strobes up.
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (ram_st == ACCESS) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (ram_st == ACCESS) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      default: ;
    endcase
  end

  arb_stall_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_stall (
    .CLK  (CLK),
    .nRST (nRST),
    .clr  (state_q == IDLE),
    .en   (is_grant(next_state)),
    .flag (timeout)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected wait releases, a monitor pops them.
module tb_mem_arbiter;

  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = '0;
  logic [1:0]  ramstate = FREE;
  logic        timeout;

  typedef struct {
    logic  is_d;
    logic  chk_data;
    word_t data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_arbiter #(.MAX_WAIT(64), .CNT_W(7)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .timeout  (timeout)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic expect_rel(input logic is_d, input logic chk, input word_t data);
    exp_t e;
    e.is_d     = is_d;
    e.chk_data = chk;
    e.data     = data;
    sb.push_back(e);
  endtask

  task automatic take(input logic is_d, input word_t data);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_release: %s wait went low with nothing expected", is_d ? "dwait" : "iwait");
    end else begin
      e = sb.pop_front();
      check("release_port", {31'd0, is_d}, {31'd0, e.is_d});
      if (e.chk_data)
        check(is_d ? "dload" : "iload", data, e.data);
    end
  endtask

  // Monitor: every low wait must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (nRST) begin
      if (!iwait) take(1'b0, iload);
      if (!dwait) take(1'b1, dload);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Two simultaneous readers; grant order depends on the build.
  task automatic dual_read(input logic d_first);
    word_t a_first, a_second;
    cyc();
    iREN = 1'b1; iaddr = 32'h0000_0300;
    dREN = 1'b1; daddr = 32'h0000_0400;
    ramstate = ACCESS; ramload = 32'hAAAA_0001;
    a_first  = d_first ? 32'h0000_0400 : 32'h0000_0300;
    a_second = d_first ? 32'h0000_0300 : 32'h0000_0400;
    cyc();
    expect_rel(d_first, 1'b1, 32'hAAAA_0001);
    smp();
    check("dual_first_addr", ramaddr, a_first);
    check("dual_first_ren", {31'd0, ramREN}, 32'd1);
    cyc();
    if (d_first) dREN = 1'b0; else iREN = 1'b0;
    ramload = 32'hBBBB_0002;
    smp();
    check("dual_gap_idle", {31'd0, ramREN}, 32'd0);
    cyc();
    expect_rel(!d_first, 1'b1, 32'hBBBB_0002);
    smp();
    check("dual_second_addr", ramaddr, a_second);
    cyc();
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    smp();
    check("dual_done_idle", {31'd0, ramREN}, 32'd0);
  endtask

  initial begin
    // Reset state
    #12 nRST = 1'b1;
    smp();
    check("rst_iwait", {31'd0, iwait}, 32'd1);
    check("rst_dwait", {31'd0, dwait}, 32'd1);
    check("rst_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_ramstore", ramstore, 32'd0);
    check("rst_loads", iload | dload, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);

    // Icache fill, ACCESS on the third strobe cycle
    cyc();
    iREN = 1'b1; iaddr = 32'h0000_0040; ramstate = BUSY;
    smp();
    check("i_req_cycle0_ren", {31'd0, ramREN}, 32'd0);
    cyc();
    smp();
    check("i_cycle1_ren", {31'd0, ramREN}, 32'd1);
    check("i_cycle1_addr", ramaddr, 32'h0000_0040);
    check("i_cycle1_iwait", {31'd0, iwait}, 32'd1);
    cyc();
    smp();
    check("i_cycle2_ren", {31'd0, ramREN}, 32'd1);
    cyc();
    ramstate = ACCESS; ramload = 32'h2001_0005;
    expect_rel(1'b0, 1'b1, 32'h2001_0005);
    smp();
    check("i_cycle3_ren", {31'd0, ramREN}, 32'd1);
    cyc();
    iREN = 1'b0; ramstate = FREE;
    smp();
    check("i_after_iwait", {31'd0, iwait}, 32'd1);
    check("i_after_ren", {31'd0, ramREN}, 32'd0);

    // Simultaneous icache read and dcache write: write first, then read after one idle cycle
    cyc();
    iREN = 1'b1; iaddr = 32'h0000_0080;
    dWEN = 1'b1; daddr = 32'h0000_0100; dstore = 32'hDEAD_BEEF;
    ramstate = ACCESS; ramload = 32'h0BAD_F00D;
    cyc();
    expect_rel(1'b1, 1'b0, '0);
    smp();
    check("w_wen", {31'd0, ramWEN}, 32'd1);
    check("w_ren", {31'd0, ramREN}, 32'd0);
    check("w_addr", ramaddr, 32'h0000_0100);
    check("w_store", ramstore, 32'hDEAD_BEEF);
    cyc();
    dWEN = 1'b0;
    ramload = 32'h1111_2222;
    smp();
    check("w_gap_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
    cyc();
    expect_rel(1'b0, 1'b1, 32'h1111_2222);
    smp();
    check("w_then_i_addr", ramaddr, 32'h0000_0080);
    check("w_then_i_ren", {31'd0, ramREN}, 32'd1);
    cyc();
    iREN = 1'b0; ramstate = FREE;

    // Dcache read retried through ERROR for three cycles
    cyc();
    dREN = 1'b1; daddr = 32'h0000_0200; ramstate = ERROR;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      smp();
      check("err_ren_held", {31'd0, ramREN}, 32'd1);
      check("err_dwait_high", {31'd0, dwait}, 32'd1);
    end
    cyc();
    ramstate = ACCESS; ramload = 32'h1234_5678;
    expect_rel(1'b1, 1'b1, 32'h1234_5678);
    smp();
    check("err_access_ren", {31'd0, ramREN}, 32'd1);
    check("err_access_addr", ramaddr, 32'h0000_0200);
    cyc();
    dREN = 1'b0; ramstate = FREE;

    // Simultaneous reads after a data grant
`ifdef MEM_ARB_RR_EN
    dual_read(1'b0);
`else
    dual_read(1'b1);
`endif

    // Stall timeout on a BUSY icache grant
    cyc();
    iREN = 1'b1; iaddr = 32'h0000_0500; ramstate = BUSY;
    for (int k = 1; k <= 64; k++) begin
      cyc();
      if (k == 63) begin
        smp();
        check("timeout_at_63", {31'd0, timeout}, 32'd0);
      end
      if (k == 64) begin
        smp();
        check("timeout_at_64", {31'd0, timeout}, 32'd1);
        check("timeout_ren_held", {31'd0, ramREN}, 32'd1);
      end
    end
    cyc();
    cyc();
    ramstate = ACCESS; ramload = 32'h5555_AAAA;
    expect_rel(1'b0, 1'b1, 32'h5555_AAAA);
    cyc();
    iREN = 1'b0; ramstate = FREE;
    smp();
    check("timeout_sticky", {31'd0, timeout}, 32'd1);

    // Reset in the middle of a data write
    cyc();
    dWEN = 1'b1; daddr = 32'h0000_0600; dstore = 32'hCAFE_0001; ramstate = BUSY;
    cyc();
    #1;
    check("rw_wen_before", {31'd0, ramWEN}, 32'd1);
    nRST = 1'b0;
    #1;
    check("rw_wen_async_drop", {31'd0, ramWEN}, 32'd0);
    check("rw_dwait_high", {31'd0, dwait}, 32'd1);
    check("rw_timeout_clr", {31'd0, timeout}, 32'd0);
    cyc();
    nRST = 1'b1;
    smp();
    check("rw_restart_idle", {30'd0, ramREN, ramWEN}, 32'd0);
    cyc();
    ramstate = ACCESS;
    expect_rel(1'b1, 1'b0, '0);
    smp();
    check("rw_regrant_wen", {31'd0, ramWEN}, 32'd1);
    cyc();
    dWEN = 1'b0; ramstate = FREE;
    cyc();
    smp();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
